sys_cmd_master: RTL and testbench

- Host-side initiator of the Tangcores system UART command protocol; drives the byte stream the FPGA `sys` command processor consumes.
- Accepts one command request at a time, serialises opcode, arguments and payload onto a uart_tx byte interface, and collects the null-terminated config-string reply from a uart_rx byte interface.
- Used as the MCU stand-in in simulation benches and as the on-chip master for bring-up and loopback.

---
 rtl/sys_cmd_pkg.sv | 37 +++
 rtl/sys_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_sys_cmd_master.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_cmd_pkg.sv
// rtl/sys_cmd_pkg.sv - shared opcodes, FSM states and argument-length table for sys_cmd_master
//
// Purpose: definitions imported by sys_cmd_master.
//   CMD_*       opcode values of the sys UART command protocol
//   state_t     command master FSM states
//   arg_count() number of argument bytes that follow each opcode
package sys_cmd_pkg;

  localparam logic [2:0] CMD_GET_CONF = 3'd1;
  localparam logic [2:0] CMD_SET_CONF = 3'd2;
  localparam logic [2:0] CMD_OVERLAY  = 3'd3;
  localparam logic [2:0] CMD_CURSOR   = 3'd4;
  localparam logic [2:0] CMD_STRING   = 3'd5;
  localparam logic [2:0] CMD_LOADING  = 3'd6;
  localparam logic [2:0] CMD_ROM_DATA = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ARG,
    ST_PAYLOAD,
    ST_TERM,
    ST_RESP
  } state_t;

  function automatic logic [2:0] arg_count(input logic [2:0] cmd);
    case (cmd)
      CMD_SET_CONF: arg_count = 3'd4;
      CMD_OVERLAY:  arg_count = 3'd1;
      CMD_CURSOR:   arg_count = 3'd2;
      CMD_LOADING:  arg_count = 3'd1;
      CMD_ROM_DATA: arg_count = 3'd3;
      default:      arg_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sys_cmd_master.sv
// rtl/sys_cmd_master.sv - host-side initiator of the sys UART command protocol
//
// Purpose: accepts one command request, serialises opcode, arguments and payload
// onto a uart_tx byte interface, and collects the null-terminated reply.
// Optional build macro: SYS_CMD_RESP_TIMEOUT_EN adds a reply inactivity timeout.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   req_valid/req_ready/req_cmd/req_arg command request handshake
//   pl_data/pl_valid/pl_last/pl_ready   payload byte stream (cmd5, cmd7)
//   tx_data/tx_valid/tx_ready           byte stream to uart_tx
//   rx_data/rx_valid                    byte strobe from uart_rx
//   resp_data/resp_valid/resp_done      reply bytes and end-of-reply strobe
//   err                                 illegal opcode / overlong reply / timeout strobe
//   busy                                not IDLE
module sys_cmd_master
  import sys_cmd_pkg::*;
#(
  parameter int RESP_MAX_LEN        = 255,
  parameter int RESP_TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_arg,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  output logic        resp_done,
  output logic        err,
  output logic        busy
);

  state_t      state, state_nx;
  logic [2:0]  cmd;
  logic [31:0] arg;
  logic [2:0]  arg_idx;
  logic [23:0] len_cnt;
  logic [7:0]  resp_cnt;
  logic        last_pend;   // final cmd5 byte is sitting in the tx holding register
  logic        load_en;
  logic [7:0]  load_byte;
  logic        timeout;

  logic        accept, xfer, pl_take, rx_hit, resp_full;
  logic [2:0]  nargs, arg_sel;
  logic [31:0] arg_sh;

  assign accept  = req_valid && req_ready;
  assign xfer    = tx_valid && tx_ready;
  assign pl_take = pl_valid && pl_ready;
  assign nargs   = arg_count(cmd);
  assign rx_hit  = (state == ST_RESP) && rx_valid;
  // Arguments go out MSB first: byte index 0 is the most significant used byte.
  assign arg_sel = nargs - 3'd1 - arg_idx;
  assign arg_sh  = arg >> {arg_sel, 3'b000};
  assign resp_full = rx_hit && (rx_data != 8'h00) &&
                     (({1'b0, resp_cnt} + 9'd1) == RESP_MAX_LEN[8:0]);

`ifdef SYS_CMD_RESP_TIMEOUT_EN
  logic [31:0] timer;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                timer <= '0;
    else if (state != ST_RESP || rx_valid)    timer <= '0;
    else                                      timer <= timer + 32'd1;
  end
  assign timeout = (state == ST_RESP) && !rx_valid &&
                   (timer == 32'(RESP_TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (accept && req_cmd != 3'd0) state_nx = ST_OP;
      ST_OP:
        if (xfer) begin
          if (nargs != 3'd0)             state_nx = ST_ARG;
          else if (cmd == CMD_GET_CONF)  state_nx = ST_RESP;
          else if (cmd == CMD_STRING)    state_nx = ST_PAYLOAD;
          else                           state_nx = ST_IDLE;
        end
      ST_ARG:
        if (xfer && arg_idx == nargs - 3'd1)
          state_nx = (cmd == CMD_ROM_DATA && len_cnt != 24'd0) ? ST_PAYLOAD : ST_IDLE;
      ST_PAYLOAD:
        if (cmd == CMD_ROM_DATA) begin
          if (xfer && len_cnt == 24'd1) state_nx = ST_IDLE;
        end else begin
          if (xfer && last_pend) state_nx = ST_TERM;
          else if (pl_take && pl_last && pl_data == 8'h00) state_nx = ST_TERM;
        end
      ST_TERM:
        if (xfer) state_nx = ST_IDLE;
      ST_RESP:
        if ((rx_hit && (rx_data == 8'h00 || resp_full)) || timeout) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Holding register is reloaded only while empty, so every transfer is
  // followed by at least one tx_valid-low cycle.
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    pl_ready  = (state == ST_PAYLOAD) && !tx_valid;
    load_en   = 1'b0;
    load_byte = 8'h00;
    case (state)
      ST_OP: begin
        load_en   = !tx_valid;
        load_byte = {5'd0, cmd};
      end
      ST_ARG: begin
        load_en   = !tx_valid;
        load_byte = arg_sh[7:0];
      end
      ST_PAYLOAD: begin
        load_en   = pl_take && (cmd == CMD_ROM_DATA || pl_data != 8'h00);
        load_byte = pl_data;
      end
      ST_TERM: begin
        load_en   = !tx_valid;
        load_byte = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd        <= '0;
      arg        <= '0;
      arg_idx    <= '0;
      len_cnt    <= '0;
      resp_cnt   <= '0;
      last_pend  <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      resp_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_done  <= 1'b0;
      err        <= 1'b0;
      if (accept) begin
        cmd       <= req_cmd;
        arg       <= req_arg;
        len_cnt   <= req_arg[23:0];
        arg_idx   <= '0;
        resp_cnt  <= '0;
        last_pend <= 1'b0;
        if (req_cmd == 3'd0) err <= 1'b1;
      end
      if (xfer) tx_valid <= 1'b0;
      if (load_en) begin
        tx_valid <= 1'b1;
        tx_data  <= load_byte;
      end
      if (state == ST_ARG && xfer) arg_idx <= arg_idx + 3'd1;
      if (state == ST_PAYLOAD && xfer && cmd == CMD_ROM_DATA) len_cnt <= len_cnt - 24'd1;
      if (state == ST_PAYLOAD && pl_take && cmd == CMD_STRING && pl_last && pl_data != 8'h00)
        last_pend <= 1'b1;
      if (rx_hit) begin
        if (rx_data == 8'h00) begin
          resp_done <= 1'b1;
        end else begin
          resp_valid <= 1'b1;
          resp_data  <= rx_data;
          resp_cnt   <= resp_cnt + 8'd1;
          if (resp_full) begin
            resp_done <= 1'b1;
            err       <= 1'b1;
          end
        end
      end
      if (timeout) begin
        resp_done <= 1'b1;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb/tb_sys_cmd_master.sv - directed self-checking bench for sys_cmd_master
module tb_sys_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_cmd = 3'd0;
  logic [31:0] req_arg = 32'd0;
  logic [7:0]  pl_data = 8'd0;
  logic        pl_valid = 1'b0;
  logic        pl_last = 1'b0;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_done;
  logic        err;
  logic        busy;

  sys_cmd_master #(.RESP_MAX_LEN(255), .RESP_TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_arg(req_arg),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_done(resp_done),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, tx_mode = 0;
  int gap_err = 0, stab_err = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] rspq[$];
  logic prev_xfer = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // tx_ready pattern: 0 = always ready, 1 = toggles every 3 cycles, 2 = stalled
  always @(posedge clk) begin
    #1;
    cyc++;
    case (tx_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ((cyc / 3) % 2) == 0;
      default: tx_ready = 1'b0;
    endcase
  end

  // Observer on the falling edge: logs transfers and reply traffic, checks tx handshake rules.
  always @(negedge clk) begin
    if (reset) begin
      prev_xfer = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_xfer && tx_valid) gap_err++;
      if (prev_hold && (!tx_valid || tx_data !== prev_data)) stab_err++;
      prev_xfer = tx_valid && tx_ready;
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (prev_xfer) txq.push_back(tx_data);
      if (resp_valid) rspq.push_back(resp_data);
      if (resp_done) done_cnt++;
      if (err) err_cnt++;
      if (resp_done && err) both_cnt++;
    end
  end

  task automatic send_req(input logic [2:0] c, input logic [31:0] a);
    int n = 0;
    while (!req_ready && n < 2000) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_cmd = c; req_arg = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 2000) begin bad++; $display("FAIL %s_idle_timeout busy=%0b required 0", tag, busy); end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic feed(input logic [7:0] b, input logic l);
    int n = 0;
    pl_valid = 1'b1; pl_data = b; pl_last = l;
    while (!pl_ready && n < 500) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    pl_valid = 1'b0; pl_last = 1'b0;
    total++;
    if (n >= 500) begin bad++; $display("FAIL feed_timeout byte=%02h never consumed", b); end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_txq(input int sz);
    int n = 0;
    while (txq.size() < sz && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    total++;
    if (n >= 500) begin bad++; $display("FAIL txq_wait got=%0d required %0d", txq.size(), sz); end
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b required 1", req_ready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b required 0", tx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b required 0", busy); end
    total++; if (pl_ready !== 1'b0) begin bad++; $display("FAIL reset_pl_ready got=%0b required 0", pl_ready); end
    total++; if ({resp_valid, resp_done, err} !== 3'b000) begin bad++; $display("FAIL reset_resp got=%03b required 000", {resp_valid, resp_done, err}); end
  endtask

  task automatic test_set_conf();
    logic [7:0] exp[$] = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    txq.delete();
    send_req(3'd2, 32'h12345678);
    wait_idle("set_conf");
    total++; if (txq.size() != exp.size()) begin bad++; $display("FAIL set_conf_len got=%0d required %0d", txq.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin bad++; $display("FAIL set_conf_byte%0d got=%02h required %02h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_short_args();
    logic [7:0] exp[$] = '{8'h04, 8'h0A, 8'h05, 8'h03, 8'h01, 8'h06, 8'h9C};
    txq.delete();
    send_req(3'd4, 32'h0000_0A05);
    send_req(3'd3, 32'h0000_0001);
    send_req(3'd6, 32'hFFFF_FF9C);
    wait_idle("short_args");
    total++; if (txq.size() != exp.size()) begin bad++; $display("FAIL short_args_len got=%0d required %0d", txq.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin bad++; $display("FAIL short_args_byte%0d got=%02h required %02h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_string();
    logic [7:0] exp[$] = '{8'h05, 8'h48, 8'h69, 8'h00};
    txq.delete();
    send_req(3'd5, 32'd0);
    feed(8'h48, 1'b0);
    feed(8'h00, 1'b0);
    feed(8'h69, 1'b1);
    wait_idle("string");
    total++; if (txq.size() != exp.size()) begin bad++; $display("FAIL string_len got=%0d required %0d", txq.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin bad++; $display("FAIL string_byte%0d got=%02h required %02h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_rom_data();
    logic [7:0] exp[$] = '{8'h07, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    int taken = 0;
    txq.delete();
    tx_mode = 1;
    send_req(3'd7, 32'h0000_0003);
    feed(8'hAA, 1'b0);
    feed(8'hBB, 1'b0);
    feed(8'hCC, 1'b0);
    pl_valid = 1'b1; pl_data = 8'hDD;
    repeat (40) begin @(posedge clk); #1; if (pl_ready) taken++; end
    pl_valid = 1'b0;
    wait_idle("rom_data");
    tx_mode = 0;
    total++; if (taken != 0) begin bad++; $display("FAIL rom_extra_consumed got=%0d required 0", taken); end
    total++; if (txq.size() != exp.size()) begin bad++; $display("FAIL rom_len got=%0d required %0d", txq.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin bad++; $display("FAIL rom_byte%0d got=%02h required %02h", i, txq[i], exp[i]); end
    end
  endtask

  task automatic test_get_conf();
    int d0 = done_cnt, e0 = err_cnt;
    txq.delete(); rspq.delete();
    rx_byte(8'h41);
    total++; if (rspq.size() != 0) begin bad++; $display("FAIL rx_idle_ignored got=%0d required 0", rspq.size()); end
    send_req(3'd1, 32'd0);
    wait_txq(1);
    repeat (2) begin @(posedge clk); #1; end
    rx_byte(8'h54);
    rx_byte(8'h61);
    rx_byte(8'h00);
    wait_idle("get_conf");
    total++; if (txq.size() != 1 || txq[0] !== 8'h01) begin bad++; $display("FAIL get_conf_tx got=%0d bytes first=%02h required 1 byte 01", txq.size(), txq[0]); end
    total++; if (rspq.size() != 2) begin bad++; $display("FAIL get_conf_resp_len got=%0d required 2", rspq.size()); end
    total++; if (rspq[0] !== 8'h54) begin bad++; $display("FAIL get_conf_resp0 got=%02h required 54", rspq[0]); end
    total++; if (rspq[1] !== 8'h61) begin bad++; $display("FAIL get_conf_resp1 got=%02h required 61", rspq[1]); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL get_conf_done got=%0d required 1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 0) begin bad++; $display("FAIL get_conf_err got=%0d required 0", err_cnt - e0); end
  endtask

  task automatic test_overlong();
    int d0 = done_cnt, e0 = err_cnt, b0 = both_cnt;
    txq.delete(); rspq.delete();
    send_req(3'd1, 32'd0);
    wait_txq(1);
    for (int i = 0; i < 255; i++) rx_byte(8'((i % 200) + 1));
    wait_idle("overlong");
    rx_byte(8'h55);
    total++; if (rspq.size() != 255) begin bad++; $display("FAIL overlong_resp_len got=%0d required 255", rspq.size()); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL overlong_done got=%0d required 1", done_cnt - d0); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL overlong_err got=%0d required 1", err_cnt - e0); end
    total++; if (both_cnt - b0 != 1) begin bad++; $display("FAIL overlong_coincident got=%0d required 1", both_cnt - b0); end
  endtask

  task automatic test_illegal();
    int e0 = err_cnt;
    txq.delete();
    send_req(3'd0, 32'hFFFF_FFFF);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%0b required 1", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%0b required 0", busy); end
    repeat (10) begin @(posedge clk); #1; end
    total++; if (txq.size() != 0) begin bad++; $display("FAIL illegal_tx got=%0d required 0", txq.size()); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL illegal_err_count got=%0d required 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$] = '{8'h03, 8'h7F};
    int n = 0;
    txq.delete();
    send_req(3'd2, 32'hCAFEBABE);
    while (txq.size() < 2 && n < 500) begin @(negedge clk); n++; end
    tx_mode = 2;
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL reset_mid_setup tx_valid=%0b required 1", tx_valid); end
    #2 reset = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_tx_valid got=%0b required 0", tx_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_req_ready got=%0b required 1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy got=%0b required 0", busy); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tx_mode = 0;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (txq.size() != 2) begin bad++; $display("FAIL reset_mid_partial got=%0d bytes required 2", txq.size()); end
    txq.delete();
    send_req(3'd3, 32'h0000_007F);
    wait_idle("after_reset");
    total++; if (txq.size() != exp.size()) begin bad++; $display("FAIL after_reset_len got=%0d required %0d", txq.size(), exp.size()); end
    foreach (exp[i]) begin
      total++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin bad++; $display("FAIL after_reset_byte%0d got=%02h required %02h", i, txq[i], exp[i]); end
    end
  endtask

`ifdef SYS_CMD_RESP_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    logic seen_err = 1'b0;
    txq.delete();
    send_req(3'd1, 32'd0);
    while (txq.size() < 1 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (!resp_done && n < 200) begin @(negedge clk); n++; end
    seen_err = err;
    @(posedge clk); #1;
    total++; if (n < 95 || n > 110) begin bad++; $display("FAIL timeout_cycles got=%0d required about 100", n); end
    total++; if (seen_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0b required 1", seen_err); end
    wait_idle("timeout");
  endtask
`endif

  task automatic test_handshake_rules();
    total++; if (gap_err != 0) begin bad++; $display("FAIL tx_gap_violations got=%0d required 0", gap_err); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL tx_hold_violations got=%0d required 0", stab_err); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_set_conf();
    test_short_args();
    test_string();
    test_rom_data();
    test_get_conf();
    test_overlong();
    test_illegal();
    test_reset_mid();
`ifdef SYS_CMD_RESP_TIMEOUT_EN
    test_timeout();
`endif
    test_handshake_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
